// File: rtl/esl_pe_sequencer.sv
// esl_pe_sequencer
// Job sequencer for one ESL processing element. Takes a weight job, pulses
// the PE clear for one cycle, enables the PE for a full 2^BIN_LEN window while
// counting ones on its x/y streams, then offers both counts on a valid/ready
// result port.
// Ports:
//   clock, reset (async, active-low)
//   cfg_valid/cfg_ready/cfg_weight  job handshake (ready only in IDLE)
//   abort                           cancel a job in CLEAR or RUN
//   pe_weight/pe_clear/pe_enable    PE control
//   pe_out_x/pe_out_y               PE stochastic outputs
//   res_valid/res_ready/res_cnt_*   result handshake
//   busy                            job in flight (CLEAR, RUN, DONE)
module esl_pe_sequencer #(
  parameter int BIN_LEN = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BIN_LEN-1:0] cfg_weight,
  input  logic               abort,
  output logic [BIN_LEN-1:0] pe_weight,
  output logic               pe_clear,
  output logic               pe_enable,
  input  logic               pe_out_x,
  input  logic               pe_out_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [BIN_LEN:0]   res_cnt_x,
  output logic [BIN_LEN:0]   res_cnt_y,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_LEN-1:0] weight_q, weight_d;
  logic [BIN_LEN-1:0] cyc_q, cyc_d;
  logic [BIN_LEN:0]   cnt_x_q, cnt_x_d;
  logic [BIN_LEN:0]   cnt_y_q, cnt_y_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      weight_q <= '0;
      cyc_q    <= '0;
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      cyc_q    <= cyc_d;
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    weight_d = weight_q;
    cyc_d    = cyc_q;
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          weight_d = cfg_weight;
          cyc_d    = '0;
          cnt_x_d  = '0;
          cnt_y_d  = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          cyc_d   = '0;
          cnt_x_d = '0;
          cnt_y_d = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over the end-of-window transition on the same edge
        if (abort) begin
          cyc_d   = '0;
          cnt_x_d = '0;
          cnt_y_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_x_d = cnt_x_q + {{BIN_LEN{1'b0}}, pe_out_x};
          cnt_y_d = cnt_y_q + {{BIN_LEN{1'b0}}, pe_out_y};
          cyc_d   = cyc_q + 1'b1;
          // last sample of the window is counted on this same edge
          if (cyc_q == {BIN_LEN{1'b1}}) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control outputs come straight from the state register
  assign cfg_ready = (state_q == S_IDLE);
  assign pe_clear  = (state_q == S_CLEAR);
  assign pe_enable = (state_q == S_RUN);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign pe_weight = weight_q;
  assign res_cnt_x = cnt_x_q;
  assign res_cnt_y = cnt_y_q;

endmodule

// File: doc/esl_pe_sequencer.md
# esl_pe_sequencer

Job sequencer for one ESL processing element. It accepts a weight configuration and runs the PE's stochastic number generators for one full bitstream window of 2^BIN_LEN cycles. It counts the ones on the PE's x/y output streams and returns both counts through a valid/ready result port. The block sits between the layer-level scheduler and a single processing element, and owns that PE's enable, clear and weight inputs.

## Interface
- BIN_LEN, 8: binary operand width; sets the window length N = 2^BIN_LEN cycles.
- clock  in  1  system clock; every register is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  a configuration is offered on cfg_weight.
- cfg_ready  out  1  sequencer can accept a job; high only in IDLE.
- cfg_weight  in  BIN_LEN  binary weight for the job.
- abort  in  1  cancel the job in flight; ignored in IDLE and DONE.
- pe_weight  out  BIN_LEN  registered weight driving PE weight_val.
- pe_clear  out  1  active-high, one-cycle pulse driving the PE reset; restarts the SNGs and the one-counter.
- pe_enable  out  1  drives PE enable; high exactly during RUN.
- pe_out_x  in  1  PE output_val_x.
- pe_out_y  in  1  PE output_val_y.
- res_valid  out  1  result counts are available.
- res_ready  in  1  consumer accepts the result.
- res_cnt_x  out  BIN_LEN+1  count of ones on pe_out_x over the window, range 0..N.
- res_cnt_y  out  BIN_LEN+1  count of ones on pe_out_y over the window, range 0..N.
- busy  out  1  high in CLEAR, RUN and DONE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - A configuration is accepted when cfg_valid && cfg_ready at a clock edge.
  - On acceptance: capture cfg_weight into pe_weight, zero both counters and cyc_cnt, and move to CLEAR.
- CLEAR: pe_clear=1 for exactly one cycle, then move to RUN.
- RUN:
  - pe_enable=1.
  - On each edge: cnt_x += pe_out_x, cnt_y += pe_out_y, cyc_cnt += 1. cyc_cnt is BIN_LEN bits wide.
  - When the edge with cyc_cnt == N-1 is taken, move to DONE. That edge's sample is counted, so exactly N samples are taken.
- DONE:
  - res_valid=1; res_cnt_x/y hold their values.
  - On res_valid && res_ready, move to IDLE.
- Counters are BIN_LEN+1 bits, so N ones yields exactly N and never wraps.
- pe_weight holds its value from acceptance until the next acceptance, including after DONE.
- abort:
  - When abort=1 in CLEAR or RUN, the next state is IDLE.
  - pe_enable drops after that edge; no result is produced; counters are zeroed.
  - Abort has priority over the RUN→DONE transition on the same edge.
- cfg_valid outside IDLE is ignored; a pending offer is taken on the first IDLE cycle.
- Output decode: cfg_ready, busy, pe_clear, pe_enable and res_valid are decoded directly from the state register (no combinational path from inputs).

## Timing
- Reset values:
  - state=IDLE, cfg_ready=1, busy=0.
  - pe_clear=0, pe_enable=0, pe_weight=0.
  - res_valid=0, res_cnt_x=0, res_cnt_y=0.
- Reset mid-job returns everything to the reset values immediately (asynchronous); no result is emitted.
- Latency, with acceptance at edge t:
  - pe_clear is high in cycle t..t+1.
  - pe_enable is high for the N cycles following the clear cycle.
  - res_valid rises after edge t+N+1 (N+2 edges after acceptance).
- Minimum job-to-job period: N+3 cycles. This is acceptance, clear, N run cycles, one DONE cycle with res_ready=1, and a return to IDLE before the next acceptance.
- Backpressure: res_valid holds for any number of cycles while res_ready=0, with counts stable.
- res_ready while not in DONE has no effect.

## Test plan
- All-ones window: PE stub drives pe_out_x=pe_out_y=1, BIN_LEN=8, weight=0x80. Expect:
  - pe_clear pulse of 1 cycle.
  - pe_enable high for exactly 256 cycles.
  - res_cnt_x=256, res_cnt_y=256.
  - pe_weight=0x80.
- Pattern window: stub drives pe_out_x alternating 1,0 starting with 1, and pe_out_y=1 on every fourth cycle. Expect res_cnt_x=128, res_cnt_y=64.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid rises. Expect res_valid and both counts stable, cfg_ready=0, and a cfg_valid offer ignored. Then raise res_ready; expect IDLE on the next edge and the pending offer accepted one cycle later.
- Abort: assert abort on the 50th RUN cycle. Expect IDLE on the next edge and no res_valid. A follow-up all-ones job returns 256/256, proving the counters were zeroed.
- Abort on the final RUN edge (cyc_cnt=255). Expect IDLE and no result.
- Async reset: drop reset mid-RUN, between clock edges. Expect all outputs at their reset values without waiting for a clock edge, and cfg_ready=1 after release.
